// File: rtl/mem_write_checker_pkg.sv
// Shared types and width helpers for the memory-write self-check monitor.
package mem_write_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_DONE    = 2'd2,
        ST_TIMEOUT = 2'd3
    } mwc_state_e;

    function automatic int idx_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int cnt_width(input int depth);
        return idx_width(depth) + 1;
    endfunction

endpackage

// File: rtl/mwc_exp_table.sv
// Expected-value register file: one synchronous write port, one combinational read port.
module mwc_exp_table
    import mem_write_checker_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic                        CLK,
    input  logic                        wr_en,
    input  logic [idx_width(DEPTH)-1:0] wr_idx,
    input  logic [DATA_W-1:0]           wr_data,
    input  logic [ADDR_W-1:0]           wr_addr,
    input  logic [idx_width(DEPTH)-1:0] rd_idx,
    output logic [DATA_W-1:0]           rd_data,
    output logic [ADDR_W-1:0]           rd_addr
);

    logic [DATA_W-1:0] data_mem_r [DEPTH];
    logic [ADDR_W-1:0] addr_mem_r [DEPTH];

    // Table contents deliberately survive reset so a run can be repeated without reloading.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            data_mem_r[wr_idx] <= wr_data;
            addr_mem_r[wr_idx] <= wr_addr;
        end
    end

    assign rd_data = data_mem_r[rd_idx];
    assign rd_addr = addr_mem_r[rd_idx];

endmodule

// File: rtl/mem_write_checker.sv
// Passive bus monitor: checks CPU write events against a preloaded table and reports pass/fail/timeout.
module mem_write_checker
    import mem_write_checker_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int DEPTH      = 16,
    parameter int CHECK_ADDR = 0,
    parameter int TIMEOUT    = 1024
) (
    input  logic                        CLK,
    input  logic                        rst,
    input  logic                        ld_en,
    input  logic [idx_width(DEPTH)-1:0] ld_idx,
    input  logic [DATA_W-1:0]           ld_data,
    input  logic [ADDR_W-1:0]           ld_addr,
    input  logic [cnt_width(DEPTH)-1:0] num_exp,
    input  logic                        start,
    input  logic                        clear,
    input  logic                        bus_cs,
    input  logic                        bus_we,
    input  logic [ADDR_W-1:0]           bus_addr,
    input  logic [DATA_W-1:0]           bus_data,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic                        timed_out,
    output logic                        extra_wr,
    output logic [cnt_width(DEPTH)-1:0] err_cnt,
    output logic [cnt_width(DEPTH)-1:0] ev_idx,
    output logic [idx_width(DEPTH)-1:0] first_err_idx,
    output logic [DATA_W-1:0]           first_err_got
);

    localparam int IW = idx_width(DEPTH);
    localparam int CW = cnt_width(DEPTH);
    localparam int TW = $clog2(TIMEOUT);

    mwc_state_e        state_r;
    logic              strobe_q_r;
    logic [CW-1:0]     num_r;
    logic [TW-1:0]     idle_r;
    logic              busy_r, done_r, pass_r, timed_out_r, extra_wr_r;
    logic [CW-1:0]     err_cnt_r, ev_idx_r;
    logic [IW-1:0]     first_err_idx_r;
    logic [DATA_W-1:0] first_err_got_r;

    logic              event_s, mismatch_s, tbl_wr_s;
    logic [CW-1:0]     ev_next_s, num_sel_s;
    logic [DATA_W-1:0] exp_data_s;
    logic [ADDR_W-1:0] exp_addr_s;

    assign tbl_wr_s = ld_en & ~clear & (state_r == ST_IDLE);

    mwc_exp_table #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_table (
        .CLK     (CLK),
        .wr_en   (tbl_wr_s),
        .wr_idx  (ld_idx),
        .wr_data (ld_data),
        .wr_addr (ld_addr),
        .rd_idx  (ev_idx_r[IW-1:0]),
        .rd_data (exp_data_s),
        .rd_addr (exp_addr_s)
    );

    // Event detection, compare against the current table entry, and run-length selection.
    always_comb begin
        event_s    = bus_cs & bus_we & ~strobe_q_r;
        mismatch_s = (bus_data != exp_data_s) ||
                     ((CHECK_ADDR != 0) && (bus_addr != exp_addr_s));
        ev_next_s  = ev_idx_r + CW'(1);
        if (num_exp == CW'(0)) begin
            num_sel_s = CW'(1);
        end else if (num_exp > CW'(DEPTH)) begin
            num_sel_s = CW'(DEPTH);
        end else begin
            num_sel_s = num_exp;
        end
    end

    // Checker FSM with counters and registered result outputs; clear outranks every other input.
    always_ff @(posedge CLK) begin
        if (!rst) begin
            state_r         <= ST_IDLE;
            strobe_q_r      <= 1'b0;
            num_r           <= CW'(0);
            idle_r          <= TW'(0);
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
            pass_r          <= 1'b0;
            timed_out_r     <= 1'b0;
            extra_wr_r      <= 1'b0;
            err_cnt_r       <= CW'(0);
            ev_idx_r        <= CW'(0);
            first_err_idx_r <= IW'(0);
            first_err_got_r <= DATA_W'(0);
        end else begin
            strobe_q_r <= bus_cs & bus_we;
            if (clear || (state_r == ST_IDLE && start)) begin
                state_r         <= clear ? ST_IDLE : ST_ARMED;
                busy_r          <= ~clear;
                idle_r          <= TW'(0);
                num_r           <= clear ? CW'(0) : num_sel_s;
                done_r          <= 1'b0;
                pass_r          <= 1'b0;
                timed_out_r     <= 1'b0;
                extra_wr_r      <= 1'b0;
                err_cnt_r       <= CW'(0);
                ev_idx_r        <= CW'(0);
                first_err_idx_r <= IW'(0);
                first_err_got_r <= DATA_W'(0);
            end else begin
                case (state_r)
                    ST_ARMED: begin
                        if (event_s) begin
                            idle_r   <= TW'(0);
                            ev_idx_r <= ev_next_s;
                            if (mismatch_s) begin
                                if (err_cnt_r != CW'(DEPTH)) begin
                                    err_cnt_r <= err_cnt_r + CW'(1);
                                end
                                if (err_cnt_r == CW'(0)) begin
                                    first_err_idx_r <= ev_idx_r[IW-1:0];
                                    first_err_got_r <= bus_data;
                                end
                            end
                            if (ev_next_s == num_r) begin
                                state_r <= ST_DONE;
                                busy_r  <= 1'b0;
                                done_r  <= 1'b1;
                                pass_r  <= (err_cnt_r == CW'(0)) && !mismatch_s;
                            end
                        end else if (idle_r == TW'(TIMEOUT - 1)) begin
                            state_r     <= ST_TIMEOUT;
                            busy_r      <= 1'b0;
                            done_r      <= 1'b1;
                            timed_out_r <= 1'b1;
                        end else begin
                            idle_r <= idle_r + TW'(1);
                        end
                    end
                    ST_DONE: begin
                        if (event_s) begin
                            extra_wr_r <= 1'b1;
                        end
                    end
                    ST_IDLE, ST_TIMEOUT: begin
                        state_r <= state_r;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy          = busy_r;
    assign done          = done_r;
    assign pass          = pass_r;
    assign timed_out     = timed_out_r;
    assign extra_wr      = extra_wr_r;
    assign err_cnt       = err_cnt_r;
    assign ev_idx        = ev_idx_r;
    assign first_err_idx = first_err_idx_r;
    assign first_err_got = first_err_got_r;

endmodule
